seq_detect_ctrl: RTL and testbench

//   Run-time programmable serial pattern detector with a sequencing controller.

---
 rtl/seq_detect_ctrl.sv | 126 ++++++++++++
 tb/tb_seq_detect_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_ctrl.sv
// Run-time programmable serial pattern detector with run/target sequencing.
// Shifts qualified bits, pulses detected on every overlapping match and ends the run at the hit target.
module seq_detect_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [CNT_W-1:0]   cfg_hits,
  input  logic               start,
  input  logic               abort,
  input  logic               new_bit,
  input  logic               new_bit_valid,
  output logic               busy,
  output logic               detected,
  output logic [CNT_W-1:0]   hit_count,
  output logic               done
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_DONE} state_e;

  state_e             state_q;
  logic [MAX_LEN-1:0] pattern_q;
  logic [MAX_LEN-2:0] shift_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   fill_q;
  logic [CNT_W-1:0]   hits_q;
  logic [CNT_W-1:0]   hit_count_q;
  logic               detected_q;
  logic               done_q;

  logic [MAX_LEN-1:0] shift_d;
  logic [MAX_LEN-1:0] mask_d;
  logic [LEN_W-1:0]   cfg_len_d;
  logic [LEN_W-1:0]   run_len_d;
  logic [LEN_W-1:0]   fill_d;
  logic [CNT_W-1:0]   hit_count_d;
  logic               match_d;

  // The window only needs MAX_LEN-1 stored bits; the incoming bit completes it.
  always_comb begin
    cfg_len_d = cfg_len;
    if (cfg_len == '0) begin
      cfg_len_d = LEN_W'(1);
    end else if (cfg_len > LEN_W'(MAX_LEN)) begin
      cfg_len_d = LEN_W'(MAX_LEN);
    end
    run_len_d   = cfg_valid ? cfg_len_d : len_q;
    shift_d     = {shift_q, new_bit};
    mask_d      = ~({MAX_LEN{1'b1}} << len_q);
    match_d     = ((shift_d ^ pattern_q) & mask_d) == '0;
    fill_d      = fill_q + LEN_W'(1);
    hit_count_d = (&hit_count_q) ? hit_count_q : hit_count_q + CNT_W'(1);
  end

  // NOTE: every register here uses <= so all updates see the pre-edge values of each other.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pattern_q   <= '0;
      shift_q     <= '0;
      len_q       <= LEN_W'(1);
      fill_q      <= '0;
      hits_q      <= '0;
      hit_count_q <= '0;
      detected_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      detected_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cfg_valid) begin
            pattern_q <= cfg_pattern;
            len_q     <= cfg_len_d;
            hits_q    <= cfg_hits;
          end
          if (start) begin
            shift_q     <= '0;
            fill_q      <= '0;
            hit_count_q <= '0;
            state_q     <= (run_len_d == LEN_W'(1)) ? S_RUN : S_FILL;
          end
        end
        S_FILL: begin
          if (abort) begin
            state_q <= S_IDLE;
          end else if (new_bit_valid) begin
            shift_q <= shift_d[MAX_LEN-2:0];
            fill_q  <= fill_d;
            if (fill_d == len_q - LEN_W'(1)) state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (abort) begin
            state_q <= S_IDLE;
          end else if (new_bit_valid) begin
            shift_q <= shift_d[MAX_LEN-2:0];
            if (match_d) begin
              detected_q  <= 1'b1;
              hit_count_q <= hit_count_d;
              if ((hits_q != '0) && (hit_count_d == hits_q)) state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          if (!abort) done_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cfg_ready = (state_q == S_IDLE);
  assign busy      = (state_q == S_FILL) || (state_q == S_RUN);
  assign detected  = detected_q;
  assign hit_count = hit_count_q;
  assign done      = done_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: directed scenarios plus random traffic against a bit-history reference model.
module tb_seq_detect_ctrl;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 8;
  localparam int LEN_W   = $clog2(MAX_LEN) + 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic [CNT_W-1:0]   cfg_hits;
  logic               start;
  logic               abort;
  logic               new_bit;
  logic               new_bit_valid;
  logic               busy;
  logic               detected;
  logic [CNT_W-1:0]   hit_count;
  logic               done;

  always #5 clk = ~clk;

  seq_detect_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_hits(cfg_hits),
    .start(start), .abort(abort), .new_bit(new_bit), .new_bit_valid(new_bit_valid),
    .busy(busy), .detected(detected), .hit_count(hit_count), .done(done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 collecting, 2 target reached; bits counted since start.
  int          m_phase, m_len, m_hits, m_nbits, m_cnt;
  int unsigned m_pat, m_hist;
  bit          m_det, m_done;

  task automatic model_reset();
    m_phase = 0; m_len = 1; m_hits = 0; m_nbits = 0; m_cnt = 0;
    m_pat = 0; m_hist = 0; m_det = 0; m_done = 0;
  endtask

  task automatic model_step();
    int unsigned mask;
    if (rst) begin
      model_reset();
      return;
    end
    m_det  = 0;
    m_done = 0;
    case (m_phase)
      0: begin
        if (cfg_valid) begin
          m_pat  = cfg_pattern;
          m_len  = (cfg_len == 0) ? 1 : ((cfg_len > MAX_LEN) ? MAX_LEN : int'(cfg_len));
          m_hits = cfg_hits;
        end
        if (start) begin
          m_phase = 1; m_nbits = 0; m_hist = 0; m_cnt = 0;
        end
      end
      1: begin
        if (abort) m_phase = 0;
        else if (new_bit_valid) begin
          m_hist  = (m_hist << 1) | new_bit;
          m_nbits = m_nbits + 1;
          mask    = (1 << m_len) - 1;
          if (m_nbits >= m_len && ((m_hist ^ m_pat) & mask) == 0) begin
            m_det = 1;
            if (m_cnt < (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
            if (m_hits != 0 && m_cnt == m_hits) m_phase = 2;
          end
        end
      end
      default: begin
        m_done  = !abort;
        m_phase = 0;
      end
    endcase
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("cfg_ready", cfg_ready, m_phase == 0);
    check("busy", busy, m_phase == 1);
    check("detected", detected, m_det);
    check("hit_count", hit_count, m_cnt);
    check("done", done, m_done);
  endtask

  task automatic clear_inputs();
    rst = 0; cfg_valid = 0; cfg_pattern = '0; cfg_len = '0; cfg_hits = '0;
    start = 0; abort = 0; new_bit = 0; new_bit_valid = 0;
  endtask

  task automatic send(input bit b);
    new_bit = b; new_bit_valid = 1;
    tick();
    new_bit_valid = 0;
  endtask

  task automatic send_seq(input logic [31:0] bits, input int n, input bit gaps);
    for (int i = n - 1; i >= 0; i--) begin
      send(bits[i]);
      if (gaps) tick();
    end
  endtask

  task automatic cfg_start(input logic [MAX_LEN-1:0] pat, input int len, input int hits);
    cfg_valid = 1; cfg_pattern = pat; cfg_len = LEN_W'(len); cfg_hits = CNT_W'(hits); start = 1;
    tick();
    cfg_valid = 0; start = 0;
  endtask

  task automatic do_abort();
    abort = 1;
    tick();
    abort = 0;
  endtask

  initial begin
    clear_inputs();
    model_reset();
    rst = 1;
    tick();
    tick();
    rst = 0;
    check("rst_ready", cfg_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_count", hit_count, 0);

    // 1: single match, len 6
    cfg_start(8'b110011, 6, 0);
    send_seq(32'b110011, 6, 0);
    check("t1_det", detected, 1);
    check("t1_cnt", hit_count, 1);
    do_abort();

    // 2: overlapping matches
    cfg_start(8'b1010, 4, 0);
    send_seq(32'b1010101, 7, 0);
    check("t2_cnt", hit_count, 2);
    do_abort();

    // 3: hit target, done pulse, then ignored bits
    cfg_start(8'b00, 2, 3);
    send_seq(32'b0000, 4, 0);
    check("t3_det", detected, 1);
    tick();
    check("t3_done", done, 1);
    check("t3_ready", cfg_ready, 1);
    send_seq(32'b000, 3, 0);
    check("t3_hold", hit_count, 3);

    // 4: fill guard against the cleared shift register
    cfg_start(8'b000, 3, 0);
    send(0); check("t4_b1", detected, 0);
    send(0); check("t4_b2", detected, 0);
    send(0); check("t4_b3", detected, 1);
    do_abort();

    // 5: same as 1 with invalid cycles interleaved
    cfg_start(8'b110011, 6, 0);
    send_seq(32'b110011, 6, 1);
    check("t5_cnt", hit_count, 1);
    do_abort();

    // 6: abort on the completing bit, reset mid-run, len 0
    cfg_start(8'b1010, 4, 0);
    send_seq(32'b101, 3, 0);
    new_bit = 0; new_bit_valid = 1; abort = 1;
    tick();
    new_bit_valid = 0; abort = 0;
    check("t6_det", detected, 0);
    check("t6_cnt", hit_count, 0);
    check("t6_ready", cfg_ready, 1);
    cfg_start(8'b11, 2, 0);
    send_seq(32'b111, 3, 0);
    rst = 1; new_bit = 1; new_bit_valid = 1;
    tick();
    rst = 0; new_bit_valid = 0;
    check("t6_rst_cnt", hit_count, 0);
    check("t6_rst_busy", busy, 0);
    cfg_start(8'hFF, 0, 0);
    check("t6_len0_busy", busy, 1);
    send(1); check("t6_len0_det", detected, 1);
    send(0); check("t6_len0_nodet", detected, 0);
    do_abort();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      rst           = ($urandom_range(0, 299) == 0);
      cfg_valid     = ($urandom_range(0, 7) == 0);
      cfg_pattern   = MAX_LEN'($urandom);
      cfg_len       = ($urandom_range(0, 1) == 0) ? LEN_W'($urandom_range(0, 4))
                                                  : LEN_W'($urandom_range(0, 15));
      cfg_hits      = CNT_W'($urandom_range(0, 5));
      start         = ($urandom_range(0, 9) == 0);
      abort         = ($urandom_range(0, 59) == 0);
      new_bit       = $urandom_range(0, 1) == 1;
      new_bit_valid = ($urandom_range(0, 9) < 7);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
